host_mem_arbiter: RTL and testbench

Two-client cache-line memory arbiter placed between the CPU's Fetch and Memory stages and the single host memory port. It accepts 512-bit line read and write requests from both stages on their `*_host` handshake ports, grants one at a time, drives the downstream memory port, and returns `tx_done` / `rd_valid` plus read data to the granted stage. A watchdog aborts transactions the memory never completes.

---
 rtl/host_mem_pkg.sv | 28 ++
 rtl/host_mem_arbiter_sel.sv | 44 ++++
 rtl/host_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_host_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/host_mem_pkg.sv
// Shared types and constants for the two-client host memory arbiter.
package host_mem_pkg;
  localparam int LINE_W_DEF = 512;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_OFF_W = 6;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } host_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    CL_FE = 1'b0,
    CL_ME = 1'b1
  } client_e;

  function automatic logic is_req(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction
endpackage

// File: rtl/host_mem_arbiter_sel.sv
// arb2_sel: two-way grant selector; round-robin when HOST_ARB_RR_EN is
// defined, otherwise fixed priority with the Memory stage winning.
module arb2_sel
  import host_mem_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_req_fe,
  input  logic    i_req_me,
  input  logic    i_take,
  output client_e o_gnt,
  output logic    o_vld
);

  assign o_vld = i_req_fe | i_req_me;

`ifdef HOST_ARB_RR_EN
  client_e r_ptr;

  // Pointer names the client that wins the next tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= CL_FE;
    end else if (i_take) begin
      r_ptr <= (o_gnt == CL_FE) ? CL_ME : CL_FE;
    end
  end

  always_comb begin
    o_gnt = CL_FE;
    unique case ({i_req_fe, i_req_me})
      2'b11:   o_gnt = r_ptr;
      2'b01:   o_gnt = CL_ME;
      default: o_gnt = CL_FE;
    endcase
  end
`else
  logic w_unused_rr;

  assign w_unused_rr = i_clk ^ i_rst ^ i_take ^ i_req_fe;
  assign o_gnt       = i_req_me ? CL_ME : CL_FE;
`endif

endmodule

// File: rtl/host_mem_arbiter.sv
// host_mem_arbiter: Fetch/Memory-stage cache-line arbiter with watchdog.
// Grant policy selected by HOST_ARB_RR_EN (see arb2_sel).
module host_mem_arbiter
  import host_mem_pkg::*;
#(
  parameter int LINE_W         = LINE_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fe_op,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic [LINE_W-1:0] fe_wdata,
  output logic [LINE_W-1:0] fe_rdata,
  output logic              fe_tx_done,
  output logic              fe_rd_valid,
  input  logic [1:0]        me_op,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [LINE_W-1:0] me_wdata,
  output logic [LINE_W-1:0] me_rdata,
  output logic              me_tx_done,
  output logic              me_rd_valid,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        r_state;
  arb_state_e        w_nxt;
  client_e           r_id;
  client_e           w_gnt;
  host_op_e          r_op;
  host_op_e          w_sel_op;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] w_sel_wdata;
  logic [LINE_W-1:0] r_fe_rdata;
  logic [LINE_W-1:0] r_me_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_abort;
  logic              w_fe_req;
  logic              w_me_req;
  logic              w_gnt_vld;
  logic              w_take;
  logic              w_tmo;
  logic              w_fin;
  logic              w_resp;
  logic              w_rd_ok;
  logic              w_unused_lo;

  assign w_fe_req = is_req(fe_op);
  assign w_me_req = is_req(me_op);

  arb2_sel u_sel (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req_fe (w_fe_req),
    .i_req_me (w_me_req),
    .i_take   (w_take),
    .o_gnt    (w_gnt),
    .o_vld    (w_gnt_vld)
  );

  assign w_sel_op    = (w_gnt == CL_ME) ? host_op_e'(me_op) : host_op_e'(fe_op);
  assign w_sel_addr  = (w_gnt == CL_ME) ? me_addr : fe_addr;
  assign w_sel_wdata = (w_gnt == CL_ME) ? me_wdata : fe_wdata;
  assign w_unused_lo = ^w_sel_addr[LINE_OFF_W-1:0];

  assign w_take = (r_state == ST_IDLE) && w_gnt_vld;
  assign w_tmo  = (r_cnt == CNT_LAST);
  assign w_fin  = (r_state == ST_BUSY) && (mem_done || w_tmo);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_gnt_vld) w_nxt = ST_BUSY;
      ST_BUSY: if (mem_done || w_tmo) w_nxt = ST_RESP;
      ST_RESP: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id    <= CL_FE;
      r_op    <= OP_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_take) begin
        r_id    <= w_gnt;
        r_op    <= w_sel_op;
        r_addr  <= {w_sel_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
        r_wdata <= w_sel_wdata;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (!mem_done && w_tmo) begin
          r_abort <= 1'b1;
        end
      end
    end
  end

  // Read lines persist per client; an abort clears the granted client's line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fe_rdata <= '0;
      r_me_rdata <= '0;
    end else if (w_fin) begin
      if (mem_done) begin
        if (r_op == OP_READ) begin
          if (r_id == CL_FE) begin
            r_fe_rdata <= mem_rdata;
          end else begin
            r_me_rdata <= mem_rdata;
          end
        end
      end else if (r_id == CL_FE) begin
        r_fe_rdata <= '0;
      end else begin
        r_me_rdata <= '0;
      end
    end
  end

  assign w_resp      = (r_state == ST_RESP);
  assign w_rd_ok     = (r_op == OP_READ) && !r_abort;
  assign fe_tx_done  = w_resp && (r_id == CL_FE);
  assign me_tx_done  = w_resp && (r_id == CL_ME);
  assign fe_rd_valid = fe_tx_done && w_rd_ok;
  assign me_rd_valid = me_tx_done && w_rd_ok;
  assign err         = w_resp && r_abort;
  assign fe_rdata    = r_fe_rdata;
  assign me_rdata    = r_me_rdata;
  assign mem_op      = (r_state == ST_BUSY) ? r_op : OP_NONE;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_host_mem_arbiter.sv
// Scoreboard bench for host_mem_arbiter (TIMEOUT_CYCLES=16).
module tb_host_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   fe_op, me_op, mem_op;
  logic [31:0]  fe_addr, me_addr, mem_addr;
  logic [511:0] fe_wdata, me_wdata, fe_rdata, me_rdata;
  logic [511:0] mem_wdata, mem_rdata;
  logic         fe_tx_done, fe_rd_valid, me_tx_done, me_rd_valid;
  logic         mem_done, err;

  typedef struct {
    bit           me;
    bit           rdv;
    bit           err;
    logic [511:0] rdata;
    logic [511:0] ordata;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic [511:0] exp_fe_rd = '0;
  logic [511:0] exp_me_rd = '0;

  host_mem_arbiter #(
    .LINE_W(512), .ADDR_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .fe_op(fe_op), .fe_addr(fe_addr), .fe_wdata(fe_wdata),
    .fe_rdata(fe_rdata), .fe_tx_done(fe_tx_done),
    .fe_rd_valid(fe_rd_valid),
    .me_op(me_op), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_rdata(me_rdata), .me_tx_done(me_tx_done),
    .me_rd_valid(me_rd_valid),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Monitor: every completion pulse pops and checks one expected response.
  always @(negedge clk) begin
    if (!rst && (fe_tx_done || me_tx_done)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done got=fe%0b/me%0b exp=none",
                 fe_tx_done, me_tx_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_client", {fe_tx_done, me_tx_done},
            e.me ? 2'b01 : 2'b10);
        chk("resp_rd_valid", e.me ? me_rd_valid : fe_rd_valid, e.rdv);
        chk("resp_other_rdv", e.me ? fe_rd_valid : me_rd_valid, 0);
        chk("resp_rdata", e.me ? me_rdata : fe_rdata, e.rdata);
        chk("resp_other_rdata", e.me ? fe_rdata : me_rdata, e.ordata);
        chk("resp_err", err, e.err);
      end
    end
  end

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_op != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_busy got=mem_op_00 exp=request_granted");
    end
  endtask

  task automatic push(input bit me, input bit rd, input bit ab,
                      input logic [511:0] line);
    exp_t e;
    e.me  = me;
    e.err = ab;
    e.rdv = rd && !ab;
    if (me) begin
      if (ab) exp_me_rd = '0;
      else if (rd) exp_me_rd = line;
      e.rdata  = exp_me_rd;
      e.ordata = exp_fe_rd;
    end else begin
      if (ab) exp_fe_rd = '0;
      else if (rd) exp_fe_rd = line;
      e.rdata  = exp_fe_rd;
      e.ordata = exp_me_rd;
    end
    sb.push_back(e);
  endtask

  task automatic txn(input bit me, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] ea,
                     input logic [511:0] wd, input int dly,
                     input logic [511:0] rd);
    bit ok;
    push(me, op == 2'b01, 1'b0, rd);
    if (me) begin
      me_op = op; me_addr = a; me_wdata = wd;
    end else begin
      fe_op = op; fe_addr = a; fe_wdata = wd;
    end
    wait_busy(ok);
    fe_op = 2'b00;
    me_op = 2'b00;
    chk("mem_op", mem_op, op);
    chk("mem_addr", mem_addr, ea);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("mem_op_hold", mem_op, op);
      if (op == 2'b10) chk("mem_wdata_hold", mem_wdata, wd);
    end
    mem_done  = 1'b1;
    mem_rdata = rd;
    @(posedge clk); #1;
    mem_done  = 1'b0;
    mem_rdata = '0;
    chk("mem_op_resp", mem_op, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit           ok;
    int           cnt;
    logic [511:0] ln;
    bit           win_me;

    rst = 1'b1;
    fe_op = '0; fe_addr = '0; fe_wdata = '0;
    me_op = '0; me_addr = '0; me_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {fe_tx_done, me_tx_done, fe_rd_valid, me_rd_valid,
                    err, mem_op}, 0);
    chk("rst_fe_rdata", fe_rdata, 0);
    chk("rst_me_rdata", me_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b0, 2'b01, 32'h0000_1234, 32'h0000_1200, '0, 3, {64{8'hA5}});
    txn(1'b1, 2'b10, 32'h0000_0040, 32'h0000_0040,
        {16{32'hDEAD_BEEF}}, 2, '0);

    fe_op = 2'b11;
    me_op = 2'b11;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mem_op != 2'b00) cnt++;
    end
    chk("rsvd_no_grant", cnt, 0);
    fe_op = 2'b00;
    me_op = 2'b00;
    mem_done  = 1'b1;
    mem_rdata = {64{8'hFF}};
    @(posedge clk); #1;
    mem_done  = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_done_idle", {mem_op, fe_rdata}, {2'b00, {64{8'hA5}}});

    fe_op = 2'b01;
    fe_addr = 32'h0000_3000;
    wait_busy(ok);
    fe_op = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_busy_ctl", {fe_tx_done, me_tx_done, fe_rd_valid,
                         me_rd_valid, err, mem_op}, 0);
    chk("rst_busy_fe_rdata", fe_rdata, 0);
    chk("rst_busy_mem_addr", mem_addr, 0);
    exp_fe_rd = '0;
    exp_me_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
`ifdef HOST_ARB_RR_EN
      win_me = (k == 1);
`else
      win_me = 1'b1;
`endif
      ln = {64{8'(8'h30 + k)}};
      push(win_me, 1'b1, 1'b0, ln);
      fe_op = 2'b01; fe_addr = 32'h0000_1000;
      me_op = 2'b01; me_addr = 32'h0000_2000;
      wait_busy(ok);
      fe_op = 2'b00;
      me_op = 2'b00;
      chk("both_grant_addr", mem_addr,
          win_me ? 32'h0000_2000 : 32'h0000_1000);
      mem_done  = 1'b1;
      mem_rdata = ln;
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_rdata = '0;
      @(posedge clk); #1;
    end

    push(1'b0, 1'b1, 1'b1, '0);
    fe_op = 2'b01;
    fe_addr = 32'h0000_4000;
    wait_busy(ok);
    fe_op = 2'b00;
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_busy16", mem_op, 2'b01);
    @(posedge clk); #1;
    chk("tmo_resp", {err, fe_tx_done, fe_rd_valid, mem_op}, 5'b11000);
    chk("tmo_rdata", fe_rdata, 0);
    @(posedge clk); #1;
    chk("tmo_idle", {err, fe_tx_done, mem_op}, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
